// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, state encoding and forwarding-priority helper for hazard_ctrl.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int CNT_W = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // MEM beats WB because it holds the younger write; a MEM load supplies load data.
  function automatic logic [1:0] fwd_code(input logic mem_hit, input logic mem_load,
                                          input logic wb_hit);
    logic [1:0] code;
    code = FWD_REG;
    if (mem_hit && mem_load) code = FWD_MEM;
    else if (mem_hit)        code = FWD_ALU;
    else if (wb_hit)         code = FWD_WB;
    return code;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: picks regfile, MEM ALU result, MEM load data or WB data.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [REG_W-1:0] mem_wraddr,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] wb_wraddr,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  // r0 is hard-wired zero, so it never matches a producer.
  assign src_live = use_src && (src != '0);
  assign mem_hit  = src_live && mem_regwrite && (src == mem_wraddr);
  assign wb_hit   = src_live && wb_regwrite && (src == wb_wraddr);
  assign sel      = fwd_code(mem_hit, mem_memread, wb_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding, EX-dependency stall/bubble, redirect drain.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 2,
  parameter int REG_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_use_rs,
  input  logic             i_use_rt,
  input  logic [REG_W-1:0] i_ex_wraddr,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_mem_wraddr,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_memread,
  input  logic [REG_W-1:0] i_wb_wraddr,
  input  logic             i_wb_regwrite,
  input  logic             i_exception,
  input  logic             i_eret,
  output logic [1:0]       o_mux_ctrl1,
  output logic [1:0]       o_mux_ctrl2,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_flush,
  output logic             o_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      o_stall_cnt,
  output logic [31:0]      o_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       sel_rs;
  logic [1:0]       sel_rt;
  logic             redirect;
  logic             ex_hazard;
  logic             redirect_acc;

  hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd_sel_rs (
    .src          (i_rs),
    .use_src      (i_use_rs),
    .mem_wraddr   (i_mem_wraddr),
    .mem_regwrite (i_mem_regwrite),
    .mem_memread  (i_mem_memread),
    .wb_wraddr    (i_wb_wraddr),
    .wb_regwrite  (i_wb_regwrite),
    .sel          (sel_rs)
  );

  hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd_sel_rt (
    .src          (i_rt),
    .use_src      (i_use_rt),
    .mem_wraddr   (i_mem_wraddr),
    .mem_regwrite (i_mem_regwrite),
    .mem_memread  (i_mem_memread),
    .wb_wraddr    (i_wb_wraddr),
    .wb_regwrite  (i_wb_regwrite),
    .sel          (sel_rt)
  );

  // Exception and eret arriving together collapse into one redirect.
  assign redirect  = i_exception || i_eret;
  assign ex_hazard = i_ex_regwrite && (i_ex_wraddr != '0) &&
                     ((i_use_rs && (i_rs == i_ex_wraddr)) ||
                      (i_use_rt && (i_rt == i_ex_wraddr)));
  assign redirect_acc = (state == ST_RUN) && redirect && !i_rst;
  assign o_busy       = (state == ST_DRAIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    o_flush     = 1'b0;
    o_stall     = 1'b0;
    o_bubble    = 1'b0;
    o_mux_ctrl1 = sel_rs;
    o_mux_ctrl2 = sel_rt;
    unique case (state)
      ST_RUN: begin
        // Flush wins over a coincident hazard: the PC takes the redirect instead of holding.
        if (redirect) begin
          o_flush = 1'b1;
          cnt_n   = DRAIN_LOAD;
          if (DRAIN_CYC > 1) state_n = ST_DRAIN;
        end else if (ex_hazard) begin
          o_stall  = 1'b1;
          o_bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_flush = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = ST_RUN;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_RUN;
    endcase
    if (i_rst) begin
      o_flush     = 1'b0;
      o_stall     = 1'b0;
      o_bubble    = 1'b0;
      o_mux_ctrl1 = FWD_REG;
      o_mux_ctrl2 = FWD_REG;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall)      o_stall_cnt <= o_stall_cnt + 32'd1;
      if (redirect_acc) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors, expectations queued, monitor compares on negedge.
module tb_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_rs, i_rt, i_ex_wraddr, i_mem_wraddr, i_wb_wraddr;
  logic       i_use_rs, i_use_rt, i_ex_regwrite, i_mem_regwrite, i_mem_memread;
  logic       i_wb_regwrite, i_exception, i_eret;
  logic [1:0] o_mux_ctrl1, o_mux_ctrl2;
  logic       o_stall, o_bubble, o_flush, o_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  hazard_ctrl #(.DRAIN_CYC(2), .REG_W(5)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rs           (i_rs),
    .i_rt           (i_rt),
    .i_use_rs       (i_use_rs),
    .i_use_rt       (i_use_rt),
    .i_ex_wraddr    (i_ex_wraddr),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_mem_wraddr   (i_mem_wraddr),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_memread  (i_mem_memread),
    .i_wb_wraddr    (i_wb_wraddr),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_exception    (i_exception),
    .i_eret         (i_eret),
    .o_mux_ctrl1    (o_mux_ctrl1),
    .o_mux_ctrl2    (o_mux_ctrl2),
    .o_stall        (o_stall),
    .o_bubble       (o_bubble),
    .o_flush        (o_flush),
    .o_busy         (o_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string      nm;
    logic [7:0] v;   // {m1, m2, stall, bubble, flush, busy}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stalls = 0;
  int   exp_flushes = 0;

  always @(negedge i_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = sb.pop_front();
      act = {o_mux_ctrl1, o_mux_ctrl2, o_stall, o_bubble, o_flush, o_busy};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {m1,m2,st,bu,fl,bz}=%b_%b_%b%b%b%b expected %b_%b_%b%b%b%b",
                 e.nm, act[7:6], act[5:4], act[3], act[2], act[1], act[0],
                 e.v[7:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic clr();
    i_rs = '0; i_rt = '0; i_use_rs = 0; i_use_rt = 0;
    i_ex_wraddr = '0; i_ex_regwrite = 0;
    i_mem_wraddr = '0; i_mem_regwrite = 0; i_mem_memread = 0;
    i_wb_wraddr = '0; i_wb_regwrite = 0;
    i_exception = 0; i_eret = 0;
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
    clr();
  endtask

  task automatic expect_o(input string nm, input logic [1:0] m1, input logic [1:0] m2,
                          input logic st, input logic bu, input logic fl, input logic bz);
    exp_t e;
    e.nm = nm;
    e.v  = {m1, m2, st, bu, fl, bz};
    sb.push_back(e);
    if (st) exp_stalls++;
    if (fl && !bz) exp_flushes++;
  endtask

  initial begin
    i_rst = 1'b1;
    clr();
    nxt(); expect_o("reset_state", 0, 0, 0, 0, 0, 0);
    nxt(); i_rst = 1'b0; expect_o("idle", 0, 0, 0, 0, 0, 0);

    // ALU producer in EX, then same producer one stage later in MEM
    nxt(); i_ex_wraddr = 5; i_ex_regwrite = 1; i_rs = 5; i_use_rs = 1;
    expect_o("alu_stall", 0, 0, 1, 1, 0, 0);
    nxt(); i_mem_wraddr = 5; i_mem_regwrite = 1; i_rs = 5; i_use_rs = 1;
    expect_o("alu_fwd_mem", 1, 0, 0, 0, 0, 0);

    nxt(); i_mem_wraddr = 7; i_mem_regwrite = 1; i_mem_memread = 1; i_rt = 7; i_use_rt = 1;
    expect_o("load_use", 0, 2, 0, 0, 0, 0);
    nxt(); i_mem_wraddr = 7; i_mem_regwrite = 1; i_mem_memread = 1;
    i_wb_wraddr = 7; i_wb_regwrite = 1; i_rs = 7; i_use_rs = 1; i_rt = 7; i_use_rt = 1;
    expect_o("mem_load_over_wb", 2, 2, 0, 0, 0, 0);
    nxt(); i_mem_wraddr = 3; i_mem_regwrite = 1; i_wb_wraddr = 3; i_wb_regwrite = 1;
    i_rs = 3; i_use_rs = 1;
    expect_o("mem_alu_over_wb", 1, 0, 0, 0, 0, 0);
    nxt(); i_wb_wraddr = 9; i_wb_regwrite = 1; i_rt = 9; i_use_rt = 1; i_rs = 4; i_use_rs = 1;
    expect_o("wb_fwd", 0, 3, 0, 0, 0, 0);
    nxt(); i_wb_wraddr = 9; i_wb_regwrite = 1; i_rt = 9; i_use_rt = 0;
    i_ex_wraddr = 9; i_ex_regwrite = 1;
    expect_o("unused_operand", 0, 0, 0, 0, 0, 0);
    nxt(); i_mem_wraddr = 6; i_mem_regwrite = 0; i_rs = 6; i_use_rs = 1;
    i_ex_wraddr = 6; i_ex_regwrite = 0;
    expect_o("no_regwrite", 0, 0, 0, 0, 0, 0);
    nxt(); i_ex_wraddr = 0; i_ex_regwrite = 1; i_mem_wraddr = 0; i_mem_regwrite = 1;
    i_wb_wraddr = 0; i_wb_regwrite = 1; i_use_rs = 1; i_use_rt = 1;
    expect_o("r0_dependency", 0, 0, 0, 0, 0, 0);
    nxt(); i_ex_wraddr = 8; i_ex_regwrite = 1; i_rt = 8; i_use_rt = 1;
    expect_o("rt_stall", 0, 0, 1, 1, 0, 0);

    // Exception over a live hazard; second request inside the drain is ignored
    nxt(); i_ex_wraddr = 4; i_ex_regwrite = 1; i_rs = 4; i_use_rs = 1; i_exception = 1;
    expect_o("exc_cycle1", 0, 0, 0, 0, 1, 0);
    nxt(); i_ex_wraddr = 4; i_ex_regwrite = 1; i_rs = 4; i_use_rs = 1; i_exception = 1;
    expect_o("exc_cycle2_drain", 0, 0, 0, 0, 1, 1);
    nxt(); i_ex_wraddr = 4; i_ex_regwrite = 1; i_rs = 4; i_use_rs = 1;
    expect_o("exc_cycle3_run", 0, 0, 1, 1, 0, 0);

    // Exception and eret together count as one redirect
    nxt(); i_exception = 1; i_eret = 1;
    expect_o("exc_eret_cycle1", 0, 0, 0, 0, 1, 0);
    nxt(); i_mem_wraddr = 2; i_mem_regwrite = 1; i_rs = 2; i_use_rs = 1;
    expect_o("exc_eret_drain_fwd", 1, 0, 0, 0, 1, 1);
    nxt(); expect_o("exc_eret_done", 0, 0, 0, 0, 0, 0);

    nxt(); i_eret = 1; expect_o("eret_cycle1", 0, 0, 0, 0, 1, 0);
    nxt(); expect_o("eret_drain", 0, 0, 0, 0, 1, 1);
    nxt(); expect_o("eret_done", 0, 0, 0, 0, 0, 0);
    nxt();

`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (o_stall_cnt !== 32'(exp_stalls)) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d expected %0d", o_stall_cnt, exp_stalls);
    end
    n_checks++;
    if (o_flush_cnt !== 32'(exp_flushes)) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected %0d", o_flush_cnt, exp_flushes);
    end
`endif

    // Asynchronous reset in the middle of a drain
    i_exception = 1; expect_o("pre_reset_exc", 0, 0, 0, 0, 1, 0);
    nxt(); i_mem_wraddr = 5; i_mem_regwrite = 1; i_rs = 5; i_use_rs = 1;
    i_ex_wraddr = 5; i_ex_regwrite = 1; i_rst = 1;
    expect_o("async_reset_mid_drain", 0, 0, 0, 0, 0, 0);
    nxt(); i_rst = 0; i_ex_wraddr = 5; i_ex_regwrite = 1; i_rs = 5; i_use_rs = 1;
    expect_o("run_after_reset", 0, 0, 1, 1, 0, 0);
    nxt();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge i_clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It sequences the decode-stage operand datapath: it drives the two 4:1 operand forwarding selects, PC/IF-ID hold, ID/EX bubble insertion and flushes.
- It handles RAW dependencies, including operands consumed in decode by branch/jr, with one-cycle stalls.
- It also sequences the exception/eret redirect drain through a small FSM with a drain counter.

Parameters:
- DRAIN_CYC, 2, cycles IF/ID and ID/EX are held flushed after exception/eret redirect (1..7)
- REG_W, 5, register address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_rs, i_rt  in  REG_W  source regs of instruction in ID
- i_use_rs, i_use_rt  in  1  ID instruction actually reads rs/rt
- i_ex_wraddr  in  REG_W  dest reg of instruction in EX
- i_ex_regwrite  in  1  EX instruction writes regfile
- i_mem_wraddr  in  REG_W  dest reg of instruction in MEM
- i_mem_regwrite, i_mem_memread  in  1  MEM instr writes reg / is load
- i_wb_wraddr  in  REG_W  dest reg of instruction in WB
- i_wb_regwrite  in  1  WB instr writes reg
- i_exception, i_eret  in  1  redirect request (level, sampled each cycle)
- o_mux_ctrl1, o_mux_ctrl2  out  2  forwarding selects: 0 regfile, 1 MEM ALU result, 2 MEM load data, 3 WB write data
- o_stall  out  1  hold PC and IF/ID
- o_bubble  out  1  load NOP into ID/EX
- o_flush  out  1  clear IF/ID and ID/EX
- o_busy  out  1  FSM not in RUN

Behaviour:
- Reset: state RUN, drain counter 0; all outputs 0 (mux_ctrl = 0).
- Register 0 never matches any producer, so a source of 0 always selects regfile.
- Forward select per operand, combinational, priority MEM > WB > regfile:
  - sel 2 if MEM regwrite, dest match and load;
  - else sel 1 if MEM regwrite and match;
  - else sel 3 if WB regwrite and match;
  - else 0.
  - Unused operand (i_use_* = 0) selects 0.
- Hazard: i_ex_regwrite, i_ex_wraddr != 0, and the wraddr matches a used source. In that case o_stall = o_bubble = 1 for exactly that cycle.
  - Next cycle the producer is in MEM and is forwarded.
  - No multi-cycle stall is needed because load data is forwarded from MEM combinationally.
- FSM states RUN, DRAIN:
  - RUN: i_exception or i_eret -> o_flush = 1 this cycle, counter <= DRAIN_CYC-1, state <= DRAIN if DRAIN_CYC > 1, else stay RUN.
  - DRAIN: o_flush = 1, o_stall = 0, o_bubble = 0, hazard detection masked. Counter decrements; at 0, state <= RUN.
  - Redirect requests during DRAIN are ignored, with no counter restart.
- Simultaneous events: flush beats hazard. In the redirect cycle o_stall = o_bubble = 0 and the PC takes the redirect.
- i_exception and i_eret together are treated as a single redirect.
- o_busy = (state == DRAIN).
- Asynchronous reset mid-DRAIN returns to RUN immediately, with outputs 0.
- Latency: forwarding/stall are 0-cycle combinational. Flush is asserted in the request cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs o_stall_cnt[31:0] (cycles with o_stall = 1) and o_flush_cnt[31:0] (redirect events accepted in RUN).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; logic is otherwise identical.

Decomposition:
- Shared package constants: FWD_REG = 2'd0, FWD_ALU = 2'd1, FWD_MEM = 2'd2, FWD_WB = 2'd3; state encodings ST_RUN, ST_DRAIN.
- One natural sub-module, fwd_sel, instantiated twice (one per operand): inputs src, use, and the MEM/WB producer fields; output 2-bit select.

Test Plan:
- Reset: assert i_rst mid-DRAIN -> o_flush = 0, o_busy = 0, mux_ctrl = 0 asynchronously; RUN after release.
- ALU back-to-back: EX writes r5, ID reads rs = r5 -> o_stall = o_bubble = 1 one cycle. Next cycle MEM regwrite r5 -> o_mux_ctrl1 = 1, o_stall = 0.
- Load-use: MEM load to r7 (memread = 1), ID rt = r7 -> o_mux_ctrl2 = 2, no stall. MEM and WB both writing r7 -> select 2 (MEM priority).
- r0 dependency: EX and MEM write r0, ID rs = rt = 0 -> mux_ctrl = 0, no stall.
- Exception with DRAIN_CYC = 2 while a hazard is present -> o_flush = 1 for 2 cycles, o_stall = 0 throughout. Second i_exception in cycle 2 is ignored; RUN in cycle 3.
- HAZARD_PERF_CNT_EN: 3 hazard stalls plus 1 eret -> o_stall_cnt = 3, o_flush_cnt = 1.
